fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch sequencer for the v6502 core. Owns the program counter, reads the opcode and 0–2 operand bytes from memory, and presents the assembled instruction to the execute stage over a valid/ack handshake. Sits between the memory bus and the opcode decoder/execute logic. Jumps, branches and interrupts redirect the PC through a load port.

## Interface
- `RESET_PC`, default 16'hFFFC: PC value loaded on reset.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `o_addr` out 16: memory read address; equals the PC register.
- `o_rd` out 1: read request; high in FETCH_OP, FETCH_LO and FETCH_HI; low otherwise and while `i_rst`=1.
- `i_rdy` in 1: memory ready; `i_data` is valid and the read completes in any cycle with `o_rd`&`i_rdy`.
- `i_data` in 8: read data.
- `o_valid` out 1: an instruction is presented.
- `o_opcode` out 8: opcode byte.
- `o_operand` out 16: {hi, lo} operand; unused bytes are 0.
- `o_len` out 2: instruction length, 1–3.
- `o_pc` out 16: address of the opcode byte.
- `i_ack` in 1: execute stage consumes the instruction; meaningful only when `o_valid`=1.
- `i_pc_load` in 1: PC redirect strobe.
- `i_pc_new` in 16: redirect target.

## Operation
- States: FETCH_OP, FETCH_LO, FETCH_HI, ISSUE. Reset enters FETCH_OP with PC=`RESET_PC`. Reset also clears `o_valid`, `o_opcode`, `o_operand`, `o_pc` and sets `o_len`=1.
- A byte is accepted on each completed read (`o_rd`&`i_rdy`). Each accepted byte increments PC modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- When `i_rdy`=0, the state, PC and `o_addr` hold.
- FETCH_OP accept:
  - latch `o_opcode`=`i_data`, `o_pc`=PC, `o_operand`=0;
  - compute the length from the opcode (op=`i_data`, hi=op[7:4], lo=op[3:0]):
    - length 1 if lo=8, lo=A, or op is 00, 40 or 60;
    - otherwise length 3 if lo is C, D, E or F, or op=20, or (lo=9 and hi[0]=1);
    - otherwise length 2, including all undefined opcodes.
  - length 1 → ISSUE; otherwise → FETCH_LO.
- FETCH_LO accept: `o_operand[7:0]`=`i_data`. Length 2 → ISSUE; length 3 → FETCH_HI.
- FETCH_HI accept: `o_operand[15:8]`=`i_data`, then → ISSUE.
- ISSUE: `o_valid`=1; outputs are stable until `i_ack`. On `i_ack`, go to FETCH_OP next cycle with `o_valid`=0. No prefetch.
- Redirect: `i_pc_load`=1 in any state has priority over everything else.
  - Next cycle: PC=`i_pc_new`, state FETCH_OP, `o_valid`=0.
  - Any read completing in the same cycle is discarded.
  - If `i_ack` and `i_pc_load` are both high in ISSUE, the instruction counts as consumed and the redirect applies.
- `i_ack` outside ISSUE is ignored.
- Reset mid-fetch or mid-ISSUE abandons the instruction; there is no partial output.

## Timing
- With `i_rdy` held at 1, count cycles from entry to FETCH_OP at cycle 0. `o_valid` rises at cycle `len`:
  - 1-byte instruction: cycle 1;
  - 2-byte instruction: cycle 2;
  - 3-byte instruction: cycle 3.
- With `i_ack` returned in the first valid cycle, the next opcode fetch starts the following cycle. Throughput is `len`+1 cycles per instruction.
- Each cycle with `i_rdy`=0 adds one cycle of latency.
- A redirect costs one cycle: `o_addr`=`i_pc_new` in the cycle after `i_pc_load`.
- `o_addr` and `o_rd` are registered-state functions only. There is no combinational path from `i_data` or `i_rdy` to `o_addr`/`o_rd`.

## Test plan
- Reset with `RESET_PC`=FFFC, memory FFFC=EA, `i_rdy`=1:
  - `o_rd`=0 during reset;
  - `o_addr`=FFFC in cycle 0;
  - `o_valid` in cycle 1 with opcode EA, len 1, `o_pc`=FFFC, operand 0000;
  - after ack, `o_addr`=FFFD.
- PC=0200, bytes A9 42: valid at cycle 2 with opcode A9, operand 0042, len 2. Then 8D 00 30 at 0202: operand 3000, len 3, `o_pc`=0202; next fetch at 0205.
- Wrap: PC=FFFE, bytes AD 34 12 at FFFE, FFFF, 0000:
  - operand 1234;
  - the next opcode address is 0001.
- Stall: `i_rdy`=0 for 3 cycles during FETCH_LO of 3-byte instruction 4C 00 80. `o_addr` holds, valid appears at cycle 6, operand 8000.
- Hold/ack: with `i_ack` low for 5 cycles, `o_valid` and all outputs stay constant. `o_rd` stays 0 throughout.
- Redirect:
  - `i_pc_load`=1 with `i_pc_new`=C000 during FETCH_LO: the partial instruction is dropped, `o_addr`=C000 next cycle, and no `o_valid` is seen for the dropped opcode.
  - Simultaneous `i_ack`+`i_pc_load` in ISSUE: the next fetch is at C000.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------
// Instruction fetch sequencer for the v6502 core. It owns the program
// counter. It reads an opcode and then 0-2 operand bytes from memory, and
// presents the assembled instruction to the execute stage over a valid/ack
// handshake. Jumps, branches and interrupts redirect the PC via i_pc_load.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   o_addr, o_rd        memory read address (the PC) and read request
//   i_rdy, i_data       memory ready and read data; a read completes on o_rd & i_rdy
//   o_valid             instruction presented
//   o_opcode, o_operand opcode byte and {hi, lo} operand (unused bytes are 0)
//   o_len, o_pc         instruction length (1-3) and address of the opcode byte
//   i_ack               execute stage consumes the presented instruction
//   i_pc_load, i_pc_new PC redirect strobe and target
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_addr,
  output logic        o_rd,
  input  logic        i_rdy,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  output logic [7:0]  o_opcode,
  output logic [15:0] o_operand,
  output logic [1:0]  o_len,
  output logic [15:0] o_pc,
  input  logic        i_ack,
  input  logic        i_pc_load,
  input  logic [15:0] i_pc_new
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_LO,
    FETCH_HI,
    ISSUE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] op_pc_q, op_pc_d;
  logic        fetching;
  logic        accept;

  // Instruction length from the opcode byte. Single-byte forms are the
  // implied/accumulator columns (lo=8, lo=A) plus BRK/RTI/RTS. Three-byte
  // forms are the absolute columns (lo=C..F), JSR, and absolute,Y (lo=9 on
  // odd rows). Everything else, including undefined opcodes, is two bytes.
  function automatic logic [1:0] instr_len(input logic [7:0] op);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = op[7:4];
    lo = op[3:0];
    if (lo == 4'h8 || lo == 4'hA || op == 8'h00 || op == 8'h40 || op == 8'h60) begin
      instr_len = 2'd1;
    end else if (lo >= 4'hC || op == 8'h20 || (lo == 4'h9 && hi[0])) begin
      instr_len = 2'd3;
    end else begin
      instr_len = 2'd2;
    end
  endfunction

  // The read request depends only on registered state. Reset is the only
  // other input that gates it.
  assign fetching  = (state_q != ISSUE);
  assign accept    = fetching && i_rdy;

  assign o_addr    = pc_q;
  assign o_rd      = fetching && !i_rst;
  assign o_valid   = (state_q == ISSUE);
  assign o_opcode  = opcode_q;
  assign o_operand = operand_q;
  assign o_len     = len_q;
  assign o_pc      = op_pc_q;

  // Next-state logic. A redirect overrides everything, including a read
  // completing in the same cycle, and an ack that arrives with it in ISSUE.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    op_pc_d   = op_pc_q;

    if (i_pc_load) begin
      pc_d    = i_pc_new;
      state_d = FETCH_OP;
    end else begin
      unique case (state_q)
        FETCH_OP: begin
          if (accept) begin
            opcode_d  = i_data;
            op_pc_d   = pc_q;
            operand_d = 16'h0000;
            len_d     = instr_len(i_data);
            pc_d      = pc_q + 16'd1;
            state_d   = (instr_len(i_data) == 2'd1) ? ISSUE : FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (accept) begin
            operand_d[7:0] = i_data;
            pc_d           = pc_q + 16'd1;
            state_d        = (len_q == 2'd2) ? ISSUE : FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (accept) begin
            operand_d[15:8] = i_data;
            pc_d            = pc_q + 16'd1;
            state_d         = ISSUE;
          end
        end
        ISSUE: begin
          if (i_ack) begin
            state_d = FETCH_OP;
          end
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= FETCH_OP;
      pc_q      <= RESET_PC;
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= 2'd1;
      op_pc_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      op_pc_q   <= op_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// ------------------
// Testbench for fetch_sequencer. A 64 KiB byte-array memory answers reads
// combinationally. A reference model derives each expected instruction
// (opcode, length, operand, arrival cycle, next PC) straight from the
// memory contents and the instruction-length rules.
module tb_fetch_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] o_addr;
  logic        o_rd;
  logic        i_rdy;
  logic [7:0]  i_data;
  logic        o_valid;
  logic [7:0]  o_opcode;
  logic [15:0] o_operand;
  logic [1:0]  o_len;
  logic [15:0] o_pc;
  logic        i_ack;
  logic        i_pc_load;
  logic [15:0] i_pc_new;

  logic [7:0]  mem [0:65535];

  int assertCount = 0;
  int failCount   = 0;

  fetch_sequencer #(.RESET_PC(16'hFFFC)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .o_addr    (o_addr),
    .o_rd      (o_rd),
    .i_rdy     (i_rdy),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_opcode  (o_opcode),
    .o_operand (o_operand),
    .o_len     (o_len),
    .o_pc      (o_pc),
    .i_ack     (i_ack),
    .i_pc_load (i_pc_load),
    .i_pc_new  (i_pc_new)
  );

  assign i_data = mem[o_addr];

  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs, then move to 1 time unit after the next
  // rising edge, where the registered outputs have settled.
  task automatic applyStimulus(input logic rdy, input logic ack, input logic load,
                               input logic [15:0] newPc);
    i_rdy     = rdy;
    i_ack     = ack;
    i_pc_load = load;
    i_pc_new  = newPc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] check %s mismatched", tag);
    end
  endtask

  // Instruction length from the opcode rules, written with plain arithmetic.
  function automatic int refLen(input logic [7:0] op);
    int v;
    int hiNib;
    int loNib;
    v     = int'(op);
    hiNib = v / 16;
    loNib = v % 16;
    if (loNib == 8 || loNib == 10 || v == 0 || v == 64 || v == 96) return 1;
    if (loNib >= 12 || v == 32 || (loNib == 9 && (hiNib % 2) == 1)) return 3;
    return 2;
  endfunction

  // Redirect the PC from whatever state the sequencer is in.
  task automatic redirectTo(input logic [15:0] target);
    applyStimulus(1'b1, 1'b0, 1'b1, target);
    checkOutput("redirectAddr", o_addr, target);
    checkOutput("redirectValid", {15'd0, o_valid}, 16'd0);
    checkOutput("redirectRd", {15'd0, o_rd}, 16'd1);
  endtask

  // Fetch one instruction, starting in cycle 0 of FETCH_OP at pc. The task
  // checks the address progression, the valid arrival cycle, the presented
  // fields, and their stability while ack is held low. It then acks, either
  // plainly or together with a redirect to loadTarget.
  task automatic runInstr(input logic [15:0] pc, input int stallAt, input int stallLen,
                          input bit randomMode, input int holdCycles,
                          input bit ackWithLoad, input logic [15:0] loadTarget);
    int          len;
    int          stalls;
    int          accepted;
    int          cyc;
    logic        rdy;
    logic        ack;
    logic [7:0]  opc;
    logic [15:0] expOperand;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] expAddr;
    logic [15:0] nextPc;

    addr1      = pc + 16'd1;
    addr2      = pc + 16'd2;
    opc        = mem[pc];
    len        = refLen(opc);
    expOperand = 16'h0000;
    if (len >= 2) expOperand[7:0]  = mem[addr1];
    if (len == 3) expOperand[15:8] = mem[addr2];
    nextPc     = pc + 16'(len);

    stalls   = 0;
    accepted = 0;
    cyc      = 0;
    while (o_valid !== 1'b1 && cyc < 40) begin
      expAddr = pc + 16'(accepted);
      checkOutput("fetchAddr", o_addr, expAddr);
      checkOutput("fetchRd", {15'd0, o_rd}, 16'd1);
      if (randomMode) begin
        rdy = ($urandom_range(0, 2) != 0);
        ack = 1'($urandom_range(0, 1));
      end else begin
        rdy = !(cyc >= stallAt && cyc < stallAt + stallLen);
        ack = 1'b0;
      end
      applyStimulus(rdy, ack, 1'b0, 16'h0000);
      if (rdy) accepted++;
      else stalls++;
      cyc++;
    end

    checkOutput("validCycle", 16'(cyc), 16'(len + stalls));
    checkOutput("valid", {15'd0, o_valid}, 16'd1);
    checkOutput("opcode", {8'd0, o_opcode}, {8'd0, opc});
    checkOutput("operand", o_operand, expOperand);
    checkOutput("len", {14'd0, o_len}, 16'(len));
    checkOutput("opPc", o_pc, pc);
    checkOutput("issueRd", {15'd0, o_rd}, 16'd0);

    for (int h = 0; h < holdCycles; h++) begin
      rdy = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(rdy, 1'b0, 1'b0, 16'h0000);
      checkOutput("holdValid", {15'd0, o_valid}, 16'd1);
      checkOutput("holdOpcode", {8'd0, o_opcode}, {8'd0, opc});
      checkOutput("holdOperand", o_operand, expOperand);
      checkOutput("holdLen", {14'd0, o_len}, 16'(len));
      checkOutput("holdPc", o_pc, pc);
      checkOutput("holdRd", {15'd0, o_rd}, 16'd0);
    end

    applyStimulus(1'b1, 1'b1, ackWithLoad, loadTarget);
    checkOutput("ackValid", {15'd0, o_valid}, 16'd0);
    checkOutput("nextAddr", o_addr, ackWithLoad ? loadTarget : nextPc);
    checkOutput("nextRd", {15'd0, o_rd}, 16'd1);
  endtask

  logic [15:0] pc;

  // Directed scenarios first, then a randomized instruction stream.
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFC] = 8'hEA;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
    mem[16'h0202] = 8'h8D; mem[16'h0203] = 8'h00; mem[16'h0204] = 8'h30;
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    mem[16'h0300] = 8'h4C; mem[16'h0301] = 8'h00; mem[16'h0302] = 8'h80;
    mem[16'h0400] = 8'h20; mem[16'h0401] = 8'h11; mem[16'h0402] = 8'h22;
    mem[16'hC000] = 8'hA2; mem[16'hC001] = 8'h05;
    for (int a = 16'h1000; a < 16'h1100; a++) mem[a] = 8'($urandom_range(0, 255));

    // Reset state.
    i_rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("rstRd", {15'd0, o_rd}, 16'd0);
    checkOutput("rstValid", {15'd0, o_valid}, 16'd0);
    checkOutput("rstLen", {14'd0, o_len}, 16'd1);
    checkOutput("rstOpcode", {8'd0, o_opcode}, 16'd0);
    checkOutput("rstOperand", o_operand, 16'd0);
    checkOutput("rstPc", o_pc, 16'd0);
    checkOutput("rstAddr", o_addr, 16'hFFFC);
    i_rst = 1'b0;
    #1;

    // NOP at the reset vector, then ack; the next fetch is at FFFD.
    runInstr(16'hFFFC, -1, 0, 1'b0, 0, 1'b0, 16'h0000);

    // Two- and three-byte instructions back to back.
    redirectTo(16'h0200);
    runInstr(16'h0200, -1, 0, 1'b0, 0, 1'b0, 16'h0000);
    runInstr(16'h0202, -1, 0, 1'b0, 0, 1'b0, 16'h0000);

    // PC wraps from FFFF to 0000 mid-instruction.
    redirectTo(16'hFFFE);
    runInstr(16'hFFFE, -1, 0, 1'b0, 0, 1'b0, 16'h0000);

    // Three-cycle stall in FETCH_LO, then hold ISSUE for five cycles.
    redirectTo(16'h0300);
    runInstr(16'h0300, 1, 3, 1'b0, 5, 1'b0, 16'h0000);

    // Redirect while in FETCH_LO drops the partial JSR.
    redirectTo(16'h0400);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("partialAddr", o_addr, 16'h0401);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hC000);
    checkOutput("dropAddr", o_addr, 16'hC000);
    checkOutput("dropValid", {15'd0, o_valid}, 16'd0);

    // Simultaneous ack and redirect in ISSUE, then a normal fetch of the target.
    runInstr(16'hC000, -1, 0, 1'b0, 0, 1'b1, 16'hC000);
    runInstr(16'hC000, -1, 0, 1'b0, 0, 1'b0, 16'h0000);

    // Reset mid-fetch abandons the instruction.
    redirectTo(16'h0200);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    i_rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("midRstValid", {15'd0, o_valid}, 16'd0);
    checkOutput("midRstAddr", o_addr, 16'hFFFC);
    checkOutput("midRstOpcode", {8'd0, o_opcode}, 16'd0);
    checkOutput("midRstOperand", o_operand, 16'd0);
    i_rst = 1'b0;
    #1;
    runInstr(16'hFFFC, -1, 0, 1'b0, 0, 1'b0, 16'h0000);

    // Random instruction stream with random stalls, stray acks and hold times.
    redirectTo(16'h1000);
    pc = 16'h1000;
    for (int n = 0; n < 25; n++) begin
      runInstr(pc, -1, 0, 1'b1, $urandom_range(0, 3), 1'b0, 16'h0000);
      pc = pc + 16'(refLen(mem[pc]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
